// File: rtl/cmd_encoder.sv
// ASCII-to-command-word encoder: parses whitespace-separated hex tokens into 16-bit words
// and queues them in a FIFO presented on a valid/ready command port.
module cmd_encoder #(
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 4,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic             cmd_valid,
    output logic [15:0]      cmd_data,
    input  logic             cmd_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             token_err,
    output logic [7:0]       err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ND_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [ND_W-1:0] ND_MAX = ND_W'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

    state_t           state, state_next;
    logic [15:0]      acc;
    logic [ND_W-1:0]  ndig;
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [15:0]      hold;

    logic       is_hex, is_term;
    logic [3:0] digit;
    logic       full, accept, pop;
    logic       load_first, shift_digit, push, drop;

    always_comb begin
        is_hex  = 1'b0;
        digit   = '0;
        is_term = char_data inside {8'h20, 8'h09, 8'h0A, 8'h0D};
        if (char_data >= 8'h30 && char_data <= 8'h39) begin
            is_hex = 1'b1;
            digit  = char_data[3:0];
        end else if ((char_data >= 8'h41 && char_data <= 8'h46) ||
                     (char_data >= 8'h61 && char_data <= 8'h66)) begin
            is_hex = 1'b1;
            digit  = char_data[3:0] + 4'd9;
        end
    end

    assign full       = (count == CNT_W'(DEPTH));
    assign pop        = (count != '0) && cmd_ready;
    assign cmd_valid  = (count != '0);
    // Once drained, the last popped word is held so the bus never shows stale slots.
    assign cmd_data   = cmd_valid ? mem[rd_ptr] : hold;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            unique case (state)
                IDLE:    if (is_hex) state_next = ACCUM;
                         else if (!is_term) state_next = DISCARD;
                ACCUM:   if (is_term) state_next = IDLE;
                         else if (!is_hex || ndig == ND_MAX) state_next = DISCARD;
                DISCARD: if (is_term) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        char_ready  = !(state == ACCUM && full);
        accept      = char_valid && char_ready;
        load_first  = 1'b0;
        shift_digit = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE:    load_first = is_hex;
                ACCUM: begin
                    shift_digit = is_hex && (ndig != ND_MAX);
                    push        = is_term;
                end
                DISCARD: drop = is_term;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            ndig      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold      <= '0;
            token_err <= 1'b0;
            err_count <= '0;
        end else begin
            if (load_first) begin
                acc  <= {12'h000, digit};
                ndig <= ND_W'(1);
            end else if (shift_digit) begin
                acc  <= {acc[11:0], digit};
                ndig <= ndig + ND_W'(1);
            end
            token_err <= drop;
            if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                hold   <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= acc;
    end

endmodule
